// File: rtl/tx_burst_serializer.sv
// Serial pattern transmitter with a UART-fed config loader.
// Frames load shadow registers that are committed only on word boundaries.
//
// state   | meaning
// L_IDLE  | waiting for the sync byte
// L_PAT   | collecting pattern bytes, MSB byte first
// L_CNT   | collecting burst count bytes, MSB byte first
// L_MODE  | waiting for {enable, lsb_first, continuous}
// S_IDLE  | line at idle level, waiting for a tick with work to do
// S_SEND  | shifting out a word, one bit per tick
module tx_burst_serializer #(
   parameter int                DATA_W      = 8,
   parameter int                CNT_W       = 32,
   parameter int                BIT_DIV     = 1,
   parameter logic [7:0]        SYNC_BYTE   = 8'hA5,
   parameter int                TIMEOUT_CYC = 250000,
   parameter logic              IDLE_LEVEL  = 1'b0,
   parameter logic [DATA_W-1:0] DEF_PATTERN = DATA_W'(8'hA5),
   parameter logic [2:0]        DEF_MODE    = 3'b101
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_valid,
   input  logic [7:0] cfg_data,
   output logic       tx_bit_data,
   output logic       tx_active,
   output logic       word_done,
   output logic       max_tx_flag,
   output logic       cfg_done,
   output logic       cfg_err
);
   localparam int PAT_BYTES = DATA_W / 8;
   localparam int CNT_BYTES = CNT_W / 8;
   localparam int BYTE_W    = 4;
   localparam int DIV_W     = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam int BIT_W     = $clog2(DATA_W);
   localparam int TMR_W     = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {L_IDLE, L_PAT, L_CNT, L_MODE} lstate_t;
   typedef enum logic {S_IDLE, S_SEND} tstate_t;

   lstate_t             lstate, lstate_nx;
   tstate_t             tstate, tstate_nx;
   logic [DIV_W-1:0]    div;
   logic                tick;
   logic [BYTE_W-1:0]   byte_idx, byte_idx_nx;
   logic [TMR_W-1:0]    tmr;
   logic                timeout, frame_ok;
   logic [DATA_W-1:0]   stg_pat, sh_pat, pat;
   logic [CNT_W-1:0]    stg_cnt, sh_cnt, cnt;
   logic [2:0]          sh_mode, mode;
   logic                commit_pend, commit;
   logic [DATA_W-1:0]   eff_pat, shift_q, shift_nx;
   logic [CNT_W-1:0]    eff_cnt, wcnt, wcnt_inc, wcnt_nx;
   logic [2:0]          eff_mode;
   logic [BIT_W-1:0]    bit_idx;
   logic                last_bit, can_send, load_word, go_idle, nxt_bit;

   assign tick = (div == DIV_W'(BIT_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) div <= '0;
      else      div <= tick ? '0 : div + 1'b1;
   end

   // A byte arriving on the last allowed cycle beats the timeout.
   assign timeout = (lstate != L_IDLE) && !cfg_valid && (tmr == TMR_W'(1));

   always_comb begin
      lstate_nx   = lstate;
      byte_idx_nx = byte_idx;
      frame_ok    = 1'b0;
      if (cfg_valid) begin
         case (lstate)
            L_IDLE: if (cfg_data == SYNC_BYTE) begin
               lstate_nx   = L_PAT;
               byte_idx_nx = '0;
            end
            L_PAT: if (byte_idx == BYTE_W'(PAT_BYTES - 1)) begin
               lstate_nx   = L_CNT;
               byte_idx_nx = '0;
            end else byte_idx_nx = byte_idx + 1'b1;
            L_CNT: if (byte_idx == BYTE_W'(CNT_BYTES - 1)) begin
               lstate_nx   = L_MODE;
               byte_idx_nx = '0;
            end else byte_idx_nx = byte_idx + 1'b1;
            L_MODE: begin
               lstate_nx = L_IDLE;
               frame_ok  = 1'b1;
            end
            default: lstate_nx = L_IDLE;
         endcase
      end else if (timeout) begin
         lstate_nx = L_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lstate      <= L_IDLE;
         byte_idx    <= '0;
         tmr         <= '0;
         stg_pat     <= '0;
         stg_cnt     <= '0;
         sh_pat      <= DEF_PATTERN;
         sh_cnt      <= '0;
         sh_mode     <= DEF_MODE;
         commit_pend <= 1'b0;
         cfg_done    <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         lstate   <= lstate_nx;
         byte_idx <= byte_idx_nx;
         cfg_done <= frame_ok;
         cfg_err  <= timeout;
         if (cfg_valid) tmr <= TMR_W'(TIMEOUT_CYC);
         else if (lstate != L_IDLE && tmr != '0) tmr <= tmr - 1'b1;
         if (cfg_valid && lstate == L_PAT) stg_pat <= (stg_pat << 8) | DATA_W'(cfg_data);
         if (cfg_valid && lstate == L_CNT) stg_cnt <= (stg_cnt << 8) | CNT_W'(cfg_data);
         if (frame_ok) begin
            sh_pat  <= stg_pat;
            sh_cnt  <= stg_cnt;
            sh_mode <= cfg_data[2:0];
         end
         // A newly completed frame wins over a same-cycle commit of the previous one.
         if (frame_ok)    commit_pend <= 1'b1;
         else if (commit) commit_pend <= 1'b0;
      end
   end

   assign last_bit  = (tstate == S_SEND) && (bit_idx == BIT_W'(DATA_W - 1));
   assign word_done = tick && last_bit;
   assign commit    = tick && commit_pend && ((tstate == S_IDLE) || last_bit);
   assign eff_pat   = commit ? sh_pat  : pat;
   assign eff_cnt   = commit ? sh_cnt  : cnt;
   assign eff_mode  = commit ? sh_mode : mode;
   assign wcnt_inc  = (&wcnt) ? wcnt : wcnt + 1'b1;
   assign wcnt_nx   = commit ? '0 : (word_done ? wcnt_inc : wcnt);
   assign can_send  = eff_mode[2] && (eff_mode[0] || (wcnt_nx != eff_cnt));
   assign shift_nx  = mode[1] ? (shift_q >> 1) : (shift_q << 1);
   assign nxt_bit   = mode[1] ? shift_nx[0] : shift_nx[DATA_W-1];
   assign tx_active = (tstate == S_SEND);

   always_comb begin
      tstate_nx = tstate;
      load_word = 1'b0;
      go_idle   = 1'b0;
      if (tick) begin
         case (tstate)
            S_IDLE: if (can_send) begin
               tstate_nx = S_SEND;
               load_word = 1'b1;
            end
            S_SEND: if (last_bit) begin
               if (can_send) load_word = 1'b1;
               else begin
                  tstate_nx = S_IDLE;
                  go_idle   = 1'b1;
               end
            end
            default: tstate_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tstate      <= S_IDLE;
         pat         <= DEF_PATTERN;
         cnt         <= '0;
         mode        <= DEF_MODE;
         wcnt        <= '0;
         shift_q     <= '0;
         bit_idx     <= '0;
         tx_bit_data <= IDLE_LEVEL;
         max_tx_flag <= 1'b0;
      end else begin
         tstate <= tstate_nx;
         wcnt   <= wcnt_nx;
         if (commit) begin
            pat  <= sh_pat;
            cnt  <= sh_cnt;
            mode <= sh_mode;
         end
         if (commit) max_tx_flag <= !sh_mode[0] && (sh_cnt == '0);
         else if (word_done && !mode[0] && (wcnt_inc == cnt)) max_tx_flag <= 1'b1;
         if (load_word) begin
            shift_q     <= eff_pat;
            bit_idx     <= '0;
            tx_bit_data <= eff_mode[1] ? eff_pat[0] : eff_pat[DATA_W-1];
         end else if (go_idle) begin
            tx_bit_data <= IDLE_LEVEL;
         end else if (tick && tstate == S_SEND) begin
            shift_q     <= shift_nx;
            bit_idx     <= bit_idx + 1'b1;
            tx_bit_data <= nxt_bit;
         end
      end
   end
endmodule

// File: tb/tb_tx_burst_serializer.sv
// Scoreboard bench: stimulus queues expected line-order words, monitors compare on word_done.
// Two instances: BIT_DIV=1 for most scenarios, BIT_DIV=4 for the held-bit burst.
module tb_tx_burst_serializer;
   localparam int T = 40;

   logic       clk = 1'b0;
   logic       rst1, rst4;
   logic       cfg_valid1, cfg_valid4;
   logic [7:0] cfg_data1, cfg_data4;
   logic       tx1, tx_active1, word_done1, max1, cfg_done1, cfg_err1;
   logic       tx4, tx_active4, word_done4, max4, cfg_done4, cfg_err4;

   tx_burst_serializer #(.BIT_DIV(1), .TIMEOUT_CYC(T)) dut1 (
      .clk(clk), .rst(rst1), .cfg_valid(cfg_valid1), .cfg_data(cfg_data1),
      .tx_bit_data(tx1), .tx_active(tx_active1), .word_done(word_done1),
      .max_tx_flag(max1), .cfg_done(cfg_done1), .cfg_err(cfg_err1));

   tx_burst_serializer #(.BIT_DIV(4), .TIMEOUT_CYC(T)) dut4 (
      .clk(clk), .rst(rst4), .cfg_valid(cfg_valid4), .cfg_data(cfg_data4),
      .tx_bit_data(tx4), .tx_active(tx_active4), .word_done(word_done4),
      .max_tx_flag(max4), .cfg_done(cfg_done4), .cfg_err(cfg_err4));

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   logic [7:0] q1[$], q4[$];
   logic [7:0] cont1 = 8'h00;
   bit         cont_ok1 = 1'b0, cont_ok4 = 1'b0;
   logic [31:0] s1 = '0, s4 = '0;
   int n1 = 0, n4 = 0, words1 = 0, words4 = 0, done1 = 0, err1 = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] expand4(input logic [7:0] w);
      logic [31:0] r;
      for (int i = 0; i < 8; i++) r[i*4 +: 4] = {4{w[i]}};
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst1) begin
         n1 = 0;
         s1 = '0;
      end else begin
         if (cfg_done1) done1++;
         if (cfg_err1) err1++;
         if (tx_active1) begin
            s1 = {s1[30:0], tx1};
            n1++;
         end
         if (word_done1) begin
            words1++;
            check("word1_len", n1, 8);
            if (q1.size() > 0) check("word1", {24'h0, s1[7:0]}, {24'h0, q1.pop_front()});
            else if (cont_ok1) check("word1_cont", {24'h0, s1[7:0]}, {24'h0, cont1});
            else begin
               n_chk++;
               n_fail++;
               $display("FAIL word1_unexpected: got %0h expected no word", s1[7:0]);
            end
            n1 = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst4) begin
         n4 = 0;
         s4 = '0;
      end else begin
         if (tx_active4) begin
            s4 = {s4[30:0], tx4};
            n4++;
         end
         if (word_done4) begin
            words4++;
            check("word4_len", n4, 32);
            if (q4.size() > 0) check("word4", s4, expand4(q4.pop_front()));
            else begin
               n_chk++;
               n_fail++;
               $display("FAIL word4_unexpected: got %0h expected no word", s4);
            end
            n4 = 0;
         end
      end
   end

   task automatic send(input bit to4, input logic [7:0] f[$]);
      foreach (f[i]) begin
         if (to4) begin cfg_data4 = f[i]; cfg_valid4 = 1'b1; end
         else begin cfg_data1 = f[i]; cfg_valid1 = 1'b1; end
         @(negedge clk);
      end
      cfg_valid1 = 1'b0;
      cfg_valid4 = 1'b0;
   endtask

   task automatic sync_word1();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (word_done1) break;
      end
      check("sync_word1", {31'h0, word_done1}, 32'h1);
   endtask

   task automatic wait_words1(input int k);
      int target;
      target = words1 + k;
      for (int i = 0; i < 40 * k && words1 < target; i++) @(negedge clk);
      check("words1_progress", {31'h0, words1 >= target}, 32'h1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] frm[$];
      int i, done_b, err_b, words_b;
      rst1 = 1'b0; rst4 = 1'b0;
      cfg_valid1 = 1'b0; cfg_valid4 = 1'b0; cfg_data1 = '0; cfg_data4 = '0;
      repeat (3) @(negedge clk);
      check("reset1_outputs", {26'h0, tx1, tx_active1, word_done1, max1, cfg_done1, cfg_err1}, 32'h0);
      check("reset4_outputs", {26'h0, tx4, tx_active4, word_done4, max4, cfg_done4, cfg_err4}, 32'h0);

      // default continuous A5 from the first tick
      cont1 = 8'hA5; cont_ok1 = 1'b1;
      rst1 = 1'b1;
      @(posedge clk); #1;
      check("first_tick_bit", {30'h0, tx_active1, tx1}, 32'h3);
      wait_words1(4);

      // partial frame then stall: timeout after exactly T idle cycles, stream unchanged
      sync_word1();
      err_b = err1;
      frm = '{8'hA5, 8'hFF};
      send(1'b0, frm);
      for (i = 1; i <= 2 * T; i++) begin
         @(negedge clk);
         if (cfg_err1) break;
      end
      check("timeout_cycles", i, T);
      repeat (3) @(negedge clk);
      check("cfg_err_once", err1 - err_b, 1);
      wait_words1(2);

      // burst of two 3C words MSB-first; old word in flight completes first
      sync_word1();
      done_b = done1;
      frm = '{8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h02, 8'h04};
      send(1'b0, frm);
      check("burst_cfg_done", {31'h0, cfg_done1}, 32'h1);
      q1.push_back(8'hA5); q1.push_back(8'h3C); q1.push_back(8'h3C);
      cont_ok1 = 1'b0;
      for (i = 0; i < 200; i++) begin
         if (q1.size() == 0 && !tx_active1) break;
         @(negedge clk);
      end
      check("burst_drained", {30'h0, q1.size() == 0, tx_active1}, 32'h2);
      check("burst_idle_level", {31'h0, tx1}, 32'h0);
      check("burst_max_flag", {31'h0, max1}, 32'h1);
      words_b = words1;
      repeat (20) @(negedge clk);
      check("burst_no_restart", words1 - words_b, 0);
      check("burst_done_count", done1 - done_b, 1);

      // BIT_DIV=4: default A5 word, then two 3C LSB-first words, 32 clk each
      q4.push_back(8'hA5); q4.push_back(8'h3C); q4.push_back(8'h3C);
      rst4 = 1'b1;
      frm = '{8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h02, 8'h06};
      send(1'b1, frm);
      for (i = 0; i < 300; i++) begin
         if (q4.size() == 0 && !tx_active4) break;
         @(negedge clk);
      end
      check("div4_drained", {30'h0, q4.size() == 0, tx_active4}, 32'h2);
      check("div4_words", words4, 3);
      check("div4_idle_flag", {30'h0, tx4, max4}, 32'h1);

      // byte arriving on the last allowed cycle beats the timeout; continuous LSB-first 1B
      err_b = err1; done_b = done1;
      frm = '{8'hA5};
      send(1'b0, frm);
      repeat (T - 1) @(negedge clk);
      frm = '{8'h1B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07};
      send(1'b0, frm);
      check("late_byte_done", {31'h0, cfg_done1}, 32'h1);
      cont1 = 8'hD8; cont_ok1 = 1'b1;
      repeat (2) @(negedge clk);
      check("late_byte_no_err", err1 - err_b, 0);
      check("commit_clears_flag", {31'h0, max1}, 32'h0);
      wait_words1(3);

      // mid-word frame in continuous mode: old word intact, then 6E MSB-first
      sync_word1();
      frm = '{8'hA5, 8'h6E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05};
      send(1'b0, frm);
      check("midword_cfg_done", {31'h0, cfg_done1}, 32'h1);
      q1.push_back(8'hD8);
      cont1 = 8'h6E;
      wait_words1(3);
      check("midword_flag", {31'h0, max1}, 32'h0);

      // reset mid-word and mid-frame
      frm = '{8'hA5, 8'h11};
      send(1'b0, frm);
      @(negedge clk);
      check("pre_reset_active", {31'h0, tx_active1}, 32'h1);
      rst1 = 1'b0; #1;
      check("async_reset_outputs", {26'h0, tx1, tx_active1, word_done1, max1, cfg_done1, cfg_err1}, 32'h0);
      @(negedge clk);
      q1.delete();
      cont1 = 8'hA5;
      done_b = done1; err_b = err1;
      rst1 = 1'b1;
      @(posedge clk); #1;
      check("restart_first_bit", {30'h0, tx_active1, tx1}, 32'h3);
      @(negedge clk);
      frm = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h04};
      send(1'b0, frm);
      wait_words1(6);
      check("reset_discards_frame", done1 - done_b, 0);
      check("reset_no_timeout", err1 - err_b, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
